// File: rtl/crc_mem_pkg.sv
// Shared types, CRC-32 constants and the bit-serial word update for crc_mem_reader.
// The WRITE state exists only when CRC_MEM_READER_WRITEBACK_EN is defined.
package crc_mem_pkg;

  localparam logic [31:0] CRC32_POLY   = 32'hEDB8_8320;
  localparam logic [31:0] CRC32_INIT   = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC32_XOROUT = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    READ      = 3'd1,
    WAIT_DATA = 3'd2,
`ifdef CRC_MEM_READER_WRITEBACK_EN
    WRITE     = 3'd3,
`endif
    DONE      = 3'd4
  } state_e;

  // Reflected CRC-32: bit 0 of the word is consumed first, which walks the
  // bytes in order [7:0], [15:8], [23:16], [31:24], each LSB first.
  function automatic logic [31:0] crc32_word(input logic [31:0] crc,
                                             input logic [31:0] data);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 32; i++) begin
      if (c[0] ^ data[i]) c = (c >> 1) ^ CRC32_POLY;
      else                c = c >> 1;
    end
    return c;
  endfunction

endpackage

// File: rtl/crc32_word_update.sv
// Combinational CRC-32 update of a running CRC with one full 32-bit word.
module crc32_word_update
  import crc_mem_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [31:0] data_in,
  output logic [31:0] crc_out
);

  assign crc_out = crc32_word(crc_in, data_in);

endmodule

// File: rtl/crc_mem_reader.sv
// Avalon-MM master that reads num_words words from base_addr and computes CRC-32.
// Optional CRC write-back to result_addr is enabled by CRC_MEM_READER_WRITEBACK_EN.
module crc_mem_reader
  import crc_mem_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   num_words,
  input  logic [ADDR_W-1:0] result_addr,
  output logic              busy,
  output logic              done,
  output logic [31:0]       crc_out,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [31:0]       avm_writedata,
  output logic [3:0]        avm_byteenable,
  input  logic [DATA_W-1:0] avm_readdata,
  input  logic              avm_waitrequest,
  output logic [2:0]        dbg_state
);

  // Avalon handshake: a read or write command is held stable while
  // avm_waitrequest is 1 and is taken on the first edge where it is 0;
  // read data arrives exactly one cycle after the read is taken.

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [ADDR_W:0]     num_q, num_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic [31:0]         crc_q, crc_d;
  logic [31:0]         crc_out_q, crc_out_d;
  logic                done_q, done_d;
  logic [31:0]         crc_next;
  logic [ADDR_W:0]     count_inc;

`ifdef CRC_MEM_READER_WRITEBACK_EN
  logic [ADDR_W-1:0]   raddr_q, raddr_d;
`else
  logic                unused_result_addr;
  assign unused_result_addr = ^result_addr;
`endif

  crc32_word_update u_crc (
    .crc_in  (crc_q),
    .data_in (avm_readdata[31:0]),
    .crc_out (crc_next)
  );

  assign count_inc = count_q + (ADDR_W+1)'(1);

  always_comb begin
    state_d        = state_q;
    base_d         = base_q;
    num_d          = num_q;
    count_d        = count_q;
    crc_d          = crc_q;
    crc_out_d      = crc_out_q;
    done_d         = 1'b0;
`ifdef CRC_MEM_READER_WRITEBACK_EN
    raddr_d        = raddr_q;
`endif
    avm_read       = 1'b0;
    avm_write      = 1'b0;
    avm_address    = '0;
    avm_writedata  = '0;
    avm_byteenable = 4'h0;

    case (state_q)
      IDLE: begin
        if (start) begin
          base_d  = base_addr;
          num_d   = num_words;
`ifdef CRC_MEM_READER_WRITEBACK_EN
          raddr_d = result_addr;
`endif
          crc_d   = CRC32_INIT;
          count_d = '0;
          state_d = (num_words == '0) ? DONE : READ;
        end
      end
      READ: begin
        avm_read       = 1'b1;
        avm_byteenable = 4'hF;
        // Natural truncation gives the modulo-2^ADDR_W address wrap.
        avm_address    = base_q + count_q[ADDR_W-1:0];
        if (!avm_waitrequest) state_d = WAIT_DATA;
      end
      WAIT_DATA: begin
        crc_d   = crc_next;
        count_d = count_inc;
        if (count_inc < num_q) state_d = READ;
`ifdef CRC_MEM_READER_WRITEBACK_EN
        else                   state_d = WRITE;
`else
        else                   state_d = DONE;
`endif
      end
`ifdef CRC_MEM_READER_WRITEBACK_EN
      WRITE: begin
        avm_write      = 1'b1;
        avm_byteenable = 4'hF;
        avm_address    = raddr_q;
        avm_writedata  = crc_q ^ CRC32_XOROUT;
        if (!avm_waitrequest) state_d = DONE;
      end
`endif
      DONE: begin
        crc_out_d = crc_q ^ CRC32_XOROUT;
        done_d    = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      base_q    <= '0;
      num_q     <= '0;
      count_q   <= '0;
      crc_q     <= CRC32_INIT;
      crc_out_q <= '0;
      done_q    <= 1'b0;
`ifdef CRC_MEM_READER_WRITEBACK_EN
      raddr_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      num_q     <= num_d;
      count_q   <= count_d;
      crc_q     <= crc_d;
      crc_out_q <= crc_out_d;
      done_q    <= done_d;
`ifdef CRC_MEM_READER_WRITEBACK_EN
      raddr_q   <= raddr_d;
`endif
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign crc_out   = crc_out_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_crc_mem_reader.sv
// Directed bench for crc_mem_reader with a word memory model and a CRC scoreboard.
// Write-back checks are active when CRC_MEM_READER_WRITEBACK_EN is defined.
module tb_crc_mem_reader;

  localparam logic [31:0] POLY = 32'hEDB8_8320;
`ifdef CRC_MEM_READER_WRITEBACK_EN
  localparam int WB_EXTRA = 1;
`else
  localparam int WB_EXTRA = 0;
`endif

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [11:0] base_addr;
  logic [12:0] num_words;
  logic [11:0] result_addr;
  logic        busy;
  logic        done;
  logic [31:0] crc_out;
  logic [11:0] avm_address;
  logic        avm_read;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic [3:0]  avm_byteenable;
  logic [31:0] avm_readdata;
  logic        avm_waitrequest;
  logic [2:0]  dbg_state;

  logic [31:0] mem [0:4095];
  logic [31:0] exp_q[$];
  logic [11:0] rd_log[$];
  int          n_tests;
  int          n_fail;
  int          unexpected_done;
  int          rw_overlap;
  int          wb_count;
  logic [11:0] wb_addr;
  logic [31:0] wb_data;

  crc_mem_reader dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .start           (start),
    .base_addr       (base_addr),
    .num_words       (num_words),
    .result_addr     (result_addr),
    .busy            (busy),
    .done            (done),
    .crc_out         (crc_out),
    .avm_address     (avm_address),
    .avm_read        (avm_read),
    .avm_write       (avm_write),
    .avm_writedata   (avm_writedata),
    .avm_byteenable  (avm_byteenable),
    .avm_readdata    (avm_readdata),
    .avm_waitrequest (avm_waitrequest),
    .dbg_state       (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memory slave: latency-1 reads, write-back capture
  initial avm_readdata = '0;
  always @(posedge clk) begin
    if (avm_read && !avm_waitrequest) begin
      avm_readdata <= mem[avm_address];
      rd_log.push_back(avm_address);
    end
    if (avm_write && !avm_waitrequest) begin
      wb_count <= wb_count + 1;
      wb_addr  <= avm_address;
      wb_data  <= avm_writedata;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // scoreboard: compare crc_out against the queue on every done pulse
  always @(negedge clk) begin
    if (avm_read && avm_write) rw_overlap++;
`ifndef CRC_MEM_READER_WRITEBACK_EN
    if (avm_write !== 1'b0) rw_overlap++;
`endif
    if (done === 1'b1) begin
      if (exp_q.size() == 0) unexpected_done++;
      else check("crc_out", crc_out, exp_q.pop_front());
    end
  end

  function automatic logic [31:0] model_crc(input int base, input int n);
    logic [31:0] c;
    logic [31:0] w;
    logic [7:0]  b;
    c = 32'hFFFF_FFFF;
    for (int k = 0; k < n; k++) begin
      w = mem[(base + k) % 4096];
      for (int j = 0; j < 4; j++) begin
        b = w[8*j +: 8];
        c = c ^ {24'h0, b};
        for (int t = 0; t < 8; t++) c = c[0] ? ((c >> 1) ^ POLY) : (c >> 1);
      end
    end
    return ~c;
  endfunction

  // driver: issue one run and wait (bounded) for done; lat counts cycles after accept
  task automatic run(input logic [11:0] base, input logic [12:0] n, input logic [11:0] raddr,
                     input logic [31:0] exp, output int lat);
    rd_log.delete();
    @(negedge clk);
    start       = 1'b1;
    base_addr   = base;
    num_words   = n;
    result_addr = raddr;
    exp_q.push_back(exp);
    @(negedge clk);
    start = 1'b0;
    lat   = 1;
    while (done !== 1'b1 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    if (lat >= 200) check("done_timeout", 32'(lat), 32'd0);
  endtask

  int          lat;
  int          nw;
  int          b0;
  int          rd_before;
  logic [31:0] e;
  logic [11:0] a0;

  initial begin
    n_tests = 0; n_fail = 0; unexpected_done = 0; rw_overlap = 0; wb_count = 0;
    wb_addr = '0; wb_data = '0;
    for (int i = 0; i < 4096; i++) mem[i] = '0;
    reset_n = 1'b0; start = 1'b0; base_addr = '0; num_words = '0; result_addr = '0;
    avm_waitrequest = 1'b0;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_done", {31'h0, done}, 32'h0);
    check("rst_crc_out", crc_out, 32'h0);
    check("rst_avm_read", {31'h0, avm_read}, 32'h0);
    check("rst_avm_write", {31'h0, avm_write}, 32'h0);
    check("rst_avm_address", {20'h0, avm_address}, 32'h0);
    check("rst_avm_writedata", avm_writedata, 32'h0);
    check("rst_avm_byteenable", {28'h0, avm_byteenable}, 32'h0);
    reset_n = 1'b1;

    // one zero word: known CRC and latency
    mem[0] = 32'h0000_0000;
    run(12'h000, 13'd1, 12'h100, 32'h2144_DF1C, lat);
    check("lat_one_word", 32'(lat), 32'(4 + WB_EXTRA));
    check("rd_count_one", 32'(rd_log.size()), 32'd1);
`ifdef CRC_MEM_READER_WRITEBACK_EN
    check("wb_addr_zero", {20'h0, wb_addr}, 32'h100);
    check("wb_data_zero", wb_data, 32'h2144_DF1C);
`endif

    // "1234"
    mem[5] = 32'h3433_3231;
    run(12'h005, 13'd1, 12'h200, 32'h9BE3_E0A3, lat);
    check("rd_addr_1234", {20'h0, rd_log[0]}, 32'h005);
`ifdef CRC_MEM_READER_WRITEBACK_EN
    check("wb_data_1234", wb_data, 32'h9BE3_E0A3);
    check("wb_count", 32'(wb_count), 32'd2);
`endif

    // zero-length run
    run(12'h007, 13'd0, 12'h300, 32'h0000_0000, lat);
    check("rd_count_zero", 32'(rd_log.size()), 32'd0);
    check("lat_zero", 32'(lat), 32'd2);

    // address wrap
    mem[12'hFFF] = $urandom;
    mem[12'h000] = $urandom;
    run(12'hFFF, 13'd2, 12'h800, model_crc(12'hFFF, 2), lat);
    check("rd_count_wrap", 32'(rd_log.size()), 32'd2);
    check("rd_addr_wrap0", {20'h0, rd_log[0]}, 32'hFFF);
    check("rd_addr_wrap1", {20'h0, rd_log[1]}, 32'h000);
    check("lat_wrap", 32'(lat), 32'(6 + WB_EXTRA));

    // random multi-word runs
    for (int r = 0; r < 3; r++) begin
      nw = $urandom_range(3, 8);
      b0 = $urandom_range(0, 12'h700);
      for (int k = 0; k < nw; k++) mem[b0 + k] = $urandom;
      run(12'(b0), 13'(nw), 12'h800, model_crc(b0, nw), lat);
      check("lat_multi", 32'(lat), 32'(2 * nw + 2 + WB_EXTRA));
      check("rd_count_multi", 32'(rd_log.size()), 32'(nw));
    end

    // waitrequest stall during READ
    mem[12'h010] = $urandom;
    mem[12'h011] = $urandom;
    rd_log.delete();
    @(negedge clk);
    start = 1'b1; base_addr = 12'h010; num_words = 13'd2; result_addr = 12'h800;
    exp_q.push_back(model_crc(12'h010, 2));
    @(negedge clk);
    start = 1'b0;
    a0 = avm_address;
    check("stall_first_addr", {20'h0, a0}, 32'h010);
    avm_waitrequest = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("stall_read", {31'h0, avm_read}, 32'h1);
      check("stall_addr", {20'h0, avm_address}, {20'h0, a0});
      check("stall_state", {29'h0, dbg_state}, 32'd1);
    end
    avm_waitrequest = 1'b0;
    lat = 0;
    while (done !== 1'b1 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    if (lat >= 200) check("stall_done_timeout", 32'(lat), 32'd0);
    check("stall_rd_count", 32'(rd_log.size()), 32'd2);

    // reset mid-run, with an ignored start while busy
    for (int k = 0; k < 6; k++) mem[12'h020 + k] = $urandom;
    @(negedge clk);
    start = 1'b1; base_addr = 12'h020; num_words = 13'd6; result_addr = 12'h900;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b1; base_addr = 12'h030; num_words = 13'd1;
    @(negedge clk);
    start = 1'b0;
    reset_n = 1'b0;
    @(negedge clk);
    check("midrst_busy", {31'h0, busy}, 32'h0);
    check("midrst_done", {31'h0, done}, 32'h0);
    check("midrst_crc_out", crc_out, 32'h0);
    check("midrst_avm_read", {31'h0, avm_read}, 32'h0);
    check("midrst_avm_address", {20'h0, avm_address}, 32'h0);
    check("midrst_byteenable", {28'h0, avm_byteenable}, 32'h0);
    check("midrst_state", {29'h0, dbg_state}, 32'd0);
    reset_n = 1'b1;
    rd_before = rd_log.size();
    repeat (30) @(negedge clk);
    check("midrst_no_reads", 32'(rd_log.size()), 32'(rd_before));
    check("midrst_idle", {31'h0, busy}, 32'h0);
`ifdef CRC_MEM_READER_WRITEBACK_EN
    check("midrst_no_wb", {20'h0, wb_addr}, 32'h800);
`endif

    // recovery after reset
    run(12'h005, 13'd1, 12'h200, 32'h9BE3_E0A3, lat);
    check("recover_lat", 32'(lat), 32'(4 + WB_EXTRA));

    repeat (3) @(negedge clk);
    check("rw_overlap", 32'(rw_overlap), 32'd0);
    check("unexpected_done", 32'(unexpected_done), 32'd0);
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/crc_mem_reader.md
CRC_MEM_READER -- requirements
Module: crc_mem_reader

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, word-address width matching the 4096-word on-chip memory.
REQ-002 SHALL have parameter DATA_W, default 32, data width; only 32 is supported.
REQ-003 SHALL have port clk  input  1  single clock; all logic is rising-edge.
REQ-004 SHALL have port reset_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a CRC run.
REQ-006 SHALL have port base_addr  input  ADDR_W  first word address, sampled when start is accepted.
REQ-007 SHALL have port num_words  input  ADDR_W+1  words to process (0..4096), sampled when start is accepted.
REQ-008 SHALL have port result_addr  input  ADDR_W  word address for CRC write-back, sampled when start is accepted.
REQ-009 SHALL have port busy  output  1  high from the cycle after accept until done.
REQ-010 SHALL have port done  output  1  one-cycle completion pulse.
REQ-011 SHALL have port crc_out  output  32  final CRC, held until the next accept.
REQ-012 SHALL have Avalon-MM master ports avm_address (output, ADDR_W), avm_read (output, 1), avm_write (output, 1), avm_writedata (output, 32), avm_byteenable (output, 4), avm_readdata (input, 32) and avm_waitrequest (input, 1).

Function
REQ-013 SHALL implement FSM states IDLE, READ, WAIT_DATA, WRITE, DONE.
REQ-014 SHALL accept start only in IDLE; start in any other state SHALL be ignored.
REQ-015 SHALL, on accept, latch the inputs, set crc to 0xFFFFFFFF, zero the word counter, and go to DONE if num_words==0, else READ.
REQ-016 SHALL, in READ, drive avm_read=1, avm_byteenable=4'hF and avm_address=(base+count) mod 2^ADDR_W.
REQ-017 SHALL hold avm_address and avm_read stable while avm_waitrequest=1, and go to WAIT_DATA in the cycle after avm_waitrequest=0.
REQ-018 SHALL have read latency fixed at 1: avm_readdata is captured in WAIT_DATA, and crc is updated with the whole word in that same cycle.
REQ-019 SHALL use CRC-32 (reflected, polynomial 0xEDB88320), consuming bytes in order [7:0],[15:8],[23:16],[31:24], LSB first.
REQ-020 SHALL, after WAIT_DATA, increment count and go to READ if count<num_words, else to WRITE (write-back compiled in) or DONE.
REQ-021 SHALL, in WRITE, drive avm_write=1, avm_address=result_addr, avm_writedata=crc^0xFFFFFFFF and byteenable 4'hF, holding until avm_waitrequest=0, then go to DONE.
REQ-022 SHALL, in DONE, set crc_out=crc^0xFFFFFFFF, pulse done for one cycle and return to IDLE.
REQ-023 SHALL never assert avm_read and avm_write together, and SHALL keep at most one read outstanding.
REQ-024 SHALL wrap addresses modulo 2^ADDR_W (0xFFF+1 -> 0x000).
REQ-025 SHALL take 2 cycles per word when waitrequest is 0.

Reset
REQ-026 SHALL, while reset_n=0 at a clock edge, enter IDLE with busy=0, done=0, crc_out=0, avm_read=0, avm_write=0, avm_address=0, avm_writedata=0 and avm_byteenable=0, abandoning any run in progress without write-back.

Configuration
REQ-027 SHALL compile the WRITE state when macro CRC_MEM_READER_WRITEBACK_EN is defined; without the macro, WRITE SHALL be absent, result_addr SHALL be ignored, avm_write SHALL be tied to 0, and the last WAIT_DATA SHALL go to DONE.

Structure
REQ-028 SHALL have package crc_mem_pkg hold the FSM state enum, CRC32_POLY=0xEDB88320, CRC32_INIT=0xFFFFFFFF, CRC32_XOROUT=0xFFFFFFFF and a crc32_word update function.
REQ-029 SHALL place the combinational 32-bit CRC update in sub-module crc32_word_update, instantiated once.

Verification
REQ-030 SHALL be verified with: start, num_words=1, mem[0]=0x00000000 -> crc_out=0x2144DF1C and done 4 cycles after accept.
REQ-031 SHALL be verified with: num_words=1, word 0x34333231 ("1234") -> crc_out=0x9BE3E0A3; with write-back, mem[result_addr]=0x9BE3E0A3.
REQ-032 SHALL be verified with: num_words=0 -> no avm_read, crc_out=0x00000000, done pulse.
REQ-033 SHALL be verified with: base_addr=0xFFF, num_words=2 -> reads at 0xFFF then 0x000.
REQ-034 SHALL be verified with: avm_waitrequest held high for 3 cycles during READ -> address and read held stable, crc unchanged, result correct.
REQ-035 SHALL be verified with: reset_n low mid-run plus a start while busy -> FSM returns to IDLE with REQ-026 values, and the ignored start causes no second run.
